// File: rtl/ad9467_capture_buf_if.sv
// Random-access read port of the AD9467 capture buffer.
// The AXI4-Lite register slave holds the master side (drives rd_en/rd_addr),
// the capture buffer holds the slave side (returns rd_data/rd_valid).
interface ad9467_capture_buf_if #(
  parameter int ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;

  modport master (output rd_en, output rd_addr, input  rd_data, input  rd_valid);
  modport slave  (input  rd_en, input  rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/ad9467_capture_buf.sv
// AD9467 sample-snapshot buffer.
// After an arm (and an optional external trigger rising edge) it stores
// cfg_count samples, keeping one of every cfg_decim+1 valid samples, into a
// block RAM that is read back with one cycle of latency.
// Optional: define AD9467FMC_CAPTURE_STATS_EN to add signed min/max tracking
// of the stored samples (st_min / st_max ports).
module ad9467_capture_buf #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int DECIM_W = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [DATA_W-1:0]         adc_data,
  input  logic                      adc_valid,
  input  logic                      adc_or,
  input  logic                      cfg_arm,
  input  logic                      cfg_abort,
  input  logic                      cfg_trig_ext_en,
  input  logic                      trig_ext,
  input  logic [ADDR_W:0]           cfg_count,
  input  logic [DECIM_W-1:0]        cfg_decim,
`ifdef AD9467FMC_CAPTURE_STATS_EN
  output logic [DATA_W-1:0]         st_min,
  output logic [DATA_W-1:0]         st_max,
`endif
  ad9467_capture_buf_if.slave       rd,
  output logic                      st_busy,
  output logic                      st_done,
  output logic                      st_ovr_seen,
  output logic [ADDR_W:0]           st_wr_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int PAD_W = 32 - DATA_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t             r_state;
  logic               r_busy, r_done, r_ovr, r_ext_en, r_trig_d;
  logic [CNT_W-1:0]   r_wr_cnt, r_count;
  logic [DECIM_W-1:0] r_decim, r_dcnt;
  logic [DATA_W:0]    r_mem [DEPTH];
  logic [DATA_W:0]    r_rd_q;
  logic               r_rd_vld;

  logic [CNT_W-1:0]   w_count;
  logic               w_arm, w_trig, w_wr;

  // Zero or oversize counts mean "fill the whole buffer".
  assign w_count = (cfg_count == '0 || cfg_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cfg_count;
  // Arm is only honoured from IDLE/DONE, and abort always wins.
  assign w_arm   = cfg_arm && !cfg_abort && (r_state == S_IDLE || r_state == S_DONE);
  // Rising edge only, so a level already high at arm time does not fire.
  assign w_trig  = !r_ext_en || (trig_ext && !r_trig_d);
  assign w_wr    = (r_state == S_CAPTURE) && adc_valid && (r_dcnt == r_decim) && !cfg_abort;

  // Capture FSM with registered status outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_ext_en <= 1'b0;
      r_trig_d <= 1'b0;
      r_wr_cnt <= '0;
      r_count  <= '0;
      r_decim  <= '0;
      r_dcnt   <= '0;
    end else begin
      r_trig_d <= trig_ext;
      if (cfg_abort) begin
        // Write count is kept so software can see how far the capture got.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_ovr   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_arm) begin
              r_state  <= S_ARMED;
              r_busy   <= 1'b1;
              r_done   <= 1'b0;
              r_ovr    <= 1'b0;
              r_wr_cnt <= '0;
              r_count  <= w_count;
              r_decim  <= cfg_decim;
              r_dcnt   <= cfg_decim;  // first valid sample after entry is stored
              r_ext_en <= cfg_trig_ext_en;
            end
          end
          S_ARMED: begin
            if (w_trig) r_state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            if (w_wr) begin
              r_dcnt   <= '0;
              r_wr_cnt <= r_wr_cnt + CNT_W'(1);
              if (adc_or) r_ovr <= 1'b1;
              if (r_wr_cnt + CNT_W'(1) == r_count) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else if (adc_valid) begin
              r_dcnt <= r_dcnt + DECIM_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Sample RAM write port; no reset so it maps onto block RAM.
  always_ff @(posedge ACLK) begin
    if (w_wr) r_mem[r_wr_cnt[ADDR_W-1:0]] <= {adc_or, adc_data};
  end

  // Synchronous read: old data on a same-address collision, held between reads.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rd_q   <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= rd.rd_en;
      if (rd.rd_en) r_rd_q <= r_mem[rd.rd_addr];
    end
  end

  assign rd.rd_data  = {{PAD_W{1'b0}}, r_rd_q};
  assign rd.rd_valid = r_rd_vld;
  assign st_busy     = r_busy;
  assign st_done     = r_done;
  assign st_ovr_seen = r_ovr;
  assign st_wr_cnt   = r_wr_cnt;

`ifdef AD9467FMC_CAPTURE_STATS_EN
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  logic [DATA_W-1:0] r_min, r_max;

  // Signed running min/max of stored samples, restarted on each arm.
  always_ff @(posedge ACLK) begin
    if (ARESET || w_arm) begin
      r_min <= MAX_POS;
      r_max <= MIN_NEG;
    end else if (w_wr) begin
      if ($signed(adc_data) < $signed(r_min)) r_min <= adc_data;
      if ($signed(adc_data) > $signed(r_max)) r_max <= adc_data;
    end
  end

  assign st_min = r_min;
  assign st_max = r_max;
`endif
endmodule

// File: doc/ad9467_capture_buf.md
Name: ad9467_capture_buf

Overview:
- Sample-snapshot stage between the AD9467 LVDS deserializer (16-bit two's-complement samples plus overrange) and the AXI4-Lite register slave.
- On software arm plus trigger, writes a programmable number of optionally decimated ADC samples into an internal RAM.
- Exposes capture status and a 1-cycle-latency random-access read port that the AXI4-Lite slave maps into its read path.

Parameters:
- ADDR_W, 10: buffer address width; DEPTH = 2**ADDR_W samples.
- DATA_W, 16: ADC sample width.
- DECIM_W, 8: decimation counter width.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  synchronous, active-high reset.
- adc_data  in  DATA_W  ADC sample, two's complement.
- adc_valid  in  1  adc_data qualifier.
- adc_or  in  1  ADC overrange flag, aligned with adc_data.
- cfg_arm  in  1  single-cycle pulse; starts a capture.
- cfg_abort  in  1  single-cycle pulse; returns to IDLE.
- cfg_trig_ext_en  in  1  1 = wait for trig_ext; 0 = start immediately.
- trig_ext  in  1  external trigger level, rising-edge detected internally.
- cfg_count  in  ADDR_W+1  samples to store, 1..DEPTH.
- cfg_decim  in  DECIM_W  store one of every cfg_decim+1 valid samples.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  32  {15'b0, overrange bit, sample}.
- rd_valid  out  1  rd_data qualifier.
- st_busy  out  1  1 in ARMED or CAPTURE.
- st_done  out  1  capture complete, sticky.
- st_ovr_seen  out  1  any stored sample had adc_or=1, sticky.
- st_wr_cnt  out  ADDR_W+1  samples stored so far.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; decimation counter 0; trigger edge register 0.
- Reset mid-capture: aborts immediately; RAM contents undefined.
- Config latching:
  - cfg_count, cfg_decim and cfg_trig_ext_en are latched on an accepted cfg_arm.
  - cfg_count = 0 or cfg_count > DEPTH is clamped to DEPTH.
- FSM IDLE:
  - cfg_arm -> ARMED.
  - On entry: st_done, st_ovr_seen and st_wr_cnt clear.
- FSM ARMED:
  - trig_ext_en=0: -> CAPTURE on the next cycle.
  - trig_ext_en=1: -> CAPTURE on the first cycle trig_ext is 1 and was 0 the previous cycle.
  - A trig_ext already high at arm does not trigger.
- FSM CAPTURE:
  - Each adc_valid increments the decimation counter.
  - When the counter equals the latched decim: write {adc_or, adc_data} to RAM[st_wr_cnt], increment st_wr_cnt, reset the counter to 0.
  - The first valid sample after entry is always stored (counter starts at decim).
  - st_ovr_seen sets on any stored sample with adc_or=1.
  - Write making st_wr_cnt == count -> DONE.
- FSM DONE:
  - st_done=1, st_busy=0.
  - cfg_arm -> ARMED, clearing status the same cycle.
- Abort: cfg_abort in any state -> IDLE next cycle.
  - st_done stays 0; st_wr_cnt is held.
  - Abort has priority over arm and trigger in the same cycle.
- Ignored arm: cfg_arm while ARMED or CAPTURE is ignored.
- Read port:
  - rd_en at cycle N -> rd_data/rd_valid at N+1; rd_valid is 1 for exactly one cycle.
  - Synchronous-read RAM, infers block RAM.
  - Reads allowed in any state.
  - Same-cycle read and write to the same address returns old data.
- rd_data: bits [31:17] always 0. Between reads, rd_data holds its last value.
- Samples with adc_valid=0 are never stored or counted.

Optional Feature:
- Macro: AD9467FMC_CAPTURE_STATS_EN.
- When defined, adds two ports:
  - st_min  out  DATA_W
  - st_max  out  DATA_W
- st_min and st_max are the signed minimum and maximum of stored samples.
  - Reset to 16'h7FFF / 16'h8000.
  - Reinitialised on entry to ARMED.
  - Updated on the same cycle as each RAM write.
- When not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - ARESET high 3 cycles -> all outputs 0; st_busy=0.
  - rd_en to addr 0 -> rd_valid one cycle later.
- Immediate capture:
  - Setup: trig_ext_en=0, count=4, decim=0, ramp 0x0010..0x0013 every cycle.
  - Expect: st_done after 4 writes, st_wr_cnt=4; reads addr 0..3 return 0x00000010..0x00000013.
- Decimation with gaps:
  - Setup: decim=2, count=3, adc_valid toggling 1/0, samples 1..9 on valid cycles.
  - Expect: stored 1,4,7; st_wr_cnt=3.
- External trigger:
  - Setup: trig_ext_en=1, trig_ext held high at arm.
  - Expect: stays ARMED.
  - trig_ext low then high -> capture starts; first stored sample is the first valid sample after the trigger cycle.
- Overrange, abort and clamp:
  - A stored sample with adc_or=1 -> st_ovr_seen=1; read returns bit16=1.
  - cfg_abort with cfg_arm in the same cycle mid-capture -> IDLE, st_done=0.
  - cfg_count=0 -> DEPTH samples stored.
- Stats (macro defined):
  - Stored samples 0x8001, 0x0005, 0x7FFE -> st_min=0x8001, st_max=0x7FFE.
  - Re-arm -> st_min=0x7FFF, st_max=0x8000.
